// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer.
// Optional perf counters are enabled with `PC_SEQ_PERF_EN.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_mux.sv
// Priority select of the next PC plus IF flush and misalign pulses.
// Purely combinational; the FSM in the top decides which requests are live.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic            boot,
    input  logic            trap_req,
    input  logic            br_req,
    input  logic [XLEN-1:0] branch_target,
    input  logic            hold_all,
    input  logic            hold_soft,
    input  logic            pend_valid,
    input  logic [XLEN-1:0] pend_addr,
    input  logic [XLEN-1:0] pc,
    output logic            redir,
    output logic [XLEN-1:0] redir_addr,
    output logic [XLEN-1:0] pc_next,
    output logic            flush_if,
    output logic            misalign
);

    logic bad_tgt;

    assign bad_tgt = |branch_target[1:0];

    always_comb begin
        redir      = trap_req | br_req;
        misalign   = br_req & ~trap_req & bad_tgt;
        flush_if   = redir;
        redir_addr = branch_target;
        if (trap_req || bad_tgt) begin
            redir_addr = TRAP_VECTOR;
        end
    end

    // hold_all beats a redirect (memory wait); hold_soft loses to one
    always_comb begin
        pc_next = pc + XLEN'(INSTR_BYTES);
        if (boot) begin
            pc_next = RESET_VECTOR;
        end else if (hold_all) begin
            pc_next = pc;
        end else if (redir) begin
            pc_next = redir_addr;
        end else if (hold_soft) begin
            pc_next = pc;
        end else if (pend_valid) begin
            pc_next = pend_addr;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: boot, run, memory wait and halt handling.
// Define `PC_SEQ_PERF_EN to add saturating redirect/stall counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            imem_ready,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]     redirect_count,
    output logic [31:0]     stall_count,
`endif
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic            flush_if,
    output logic            misalign,
    output logic            halted
);

    state_t          state;
    state_t          state_nxt;
    logic            pend_valid;
    logic            pend_trap;
    logic [XLEN-1:0] pend_addr;

    logic            boot;
    logic            trap_req;
    logic            br_req;
    logic            hold_all;
    logic            hold_soft;
    logic            redir;
    logic [XLEN-1:0] redir_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (redir) begin
                    state_nxt = RUN;
                end else if (!imem_ready) begin
                    state_nxt = WAIT;
                end else if (halt_req && !stall) begin
                    state_nxt = HALT;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    state_nxt = RUN;
                end
            end
            HALT: begin
                if (trap || resume) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        boot      = 1'b0;
        trap_req  = 1'b0;
        br_req    = 1'b0;
        hold_all  = 1'b0;
        hold_soft = 1'b0;
        imem_req  = 1'b0;
        halted    = 1'b0;
        unique case (state)
            BOOT: boot = 1'b1;
            RUN: begin
                imem_req  = 1'b1;
                trap_req  = trap;
                br_req    = branch_taken;
                hold_soft = stall | ~imem_ready;
            end
            WAIT: begin
                imem_req = 1'b1;
                trap_req = trap;
                br_req   = branch_taken;
                hold_all = ~imem_ready;
            end
            HALT: begin
                halted    = 1'b1;
                trap_req  = trap;
                hold_soft = 1'b1;
            end
            default: boot = 1'b1;
        endcase
    end

    // A pending trap is never displaced by a later branch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
            pend_addr  <= '0;
        end else if (state == WAIT && !imem_ready) begin
            if (redir && (trap_req || !pend_trap)) begin
                pend_valid <= 1'b1;
                pend_trap  <= trap_req;
                pend_addr  <= redir_addr;
            end
        end else begin
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
        end
    end

    pc_next_mux #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_mux (
        .boot          (boot),
        .trap_req      (trap_req),
        .br_req        (br_req),
        .branch_target (branch_target),
        .hold_all      (hold_all),
        .hold_soft     (hold_soft),
        .pend_valid    (pend_valid),
        .pend_addr     (pend_addr),
        .pc            (pc),
        .redir         (redir),
        .redir_addr    (redir_addr),
        .pc_next       (pc_next),
        .flush_if      (flush_if),
        .misalign      (misalign)
    );

`ifdef PC_SEQ_PERF_EN
    logic run_like;

    assign run_like = (state == RUN) || (state == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_count <= '0;
            stall_count    <= '0;
        end else begin
            if (flush_if && redirect_count != '1) begin
                redirect_count <= redirect_count + 32'd1;
            end
            if (run_like && pc_next == pc && stall_count != '1) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default build, perf counters off).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        flush_if;
    logic        misalign;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap          (trap),
        .halt_req      (halt_req),
        .resume        (resume),
        .imem_ready    (imem_ready),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .flush_if      (flush_if),
        .misalign      (misalign),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc,
                           input logic e_req, input logic e_fl,
                           input logic e_mis, input logic e_halt);
        chk({tag, ".pc_next"}, pc_next, e_pc);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, e_fl});
        chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        pc = 32'h0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        trap = 1'b0;
        halt_req = 1'b0;
        resume = 1'b0;
        imem_ready = 1'b1;
        #3;
        chk_all("reset", 32'h0, 0, 0, 0, 0);

        // boot then sequential fetch
        nxt(); rst = 1'b1; #1;
        chk_all("boot", 32'h0, 0, 0, 0, 0);
        nxt(); pc = 32'h0; #1;
        chk_all("seq0", 32'h4, 1, 0, 0, 0);
        nxt(); pc = 32'h4; #1;
        chk("seq4", pc_next, 32'h8);
        nxt(); pc = 32'h8; #1;
        chk("seq8", pc_next, 32'hC);

        // aligned branch
        nxt(); pc = 32'h10; branch_taken = 1; branch_target = 32'h40; #1;
        chk_all("br", 32'h40, 1, 1, 0, 0);
        nxt(); pc = 32'h40; branch_taken = 0; #1;
        chk_all("br_after", 32'h44, 1, 0, 0, 0);

        // memory wait with a branch arriving in wait cycle 2
        nxt(); pc = 32'h20; imem_ready = 0; #1;
        chk_all("w_run", 32'h20, 1, 0, 0, 0);
        nxt(); #1;
        chk_all("w1", 32'h20, 1, 0, 0, 0);
        nxt(); branch_taken = 1; branch_target = 32'h80; #1;
        chk_all("w2_br", 32'h20, 1, 1, 0, 0);
        nxt(); branch_taken = 0; imem_ready = 1; #1;
        chk_all("w_ready", 32'h80, 1, 0, 0, 0);
        nxt(); pc = 32'h80; #1;
        chk("w_done", pc_next, 32'h84);

        // misaligned redirect, then trap+branch together
        nxt(); pc = 32'h84; branch_taken = 1; branch_target = 32'h42; #1;
        chk_all("mis", 32'h100, 1, 1, 1, 0);
        nxt(); pc = 32'h100; branch_taken = 0; #1;
        chk_all("mis_after", 32'h104, 1, 0, 0, 0);
        nxt(); pc = 32'h104; trap = 1; branch_taken = 1; #1;
        chk_all("trap_br", 32'h100, 1, 1, 0, 0);

        // stall interactions and wrap
        nxt(); pc = 32'h200; trap = 0; branch_taken = 0; stall = 1; #1;
        chk_all("stall", 32'h200, 1, 0, 0, 0);
        nxt(); trap = 1; #1;
        chk_all("stall_trap", 32'h100, 1, 1, 0, 0);
        nxt(); trap = 0; branch_taken = 1; branch_target = 32'h300; #1;
        chk_all("stall_br", 32'h300, 1, 1, 0, 0);
        nxt(); stall = 0; branch_taken = 0; pc = 32'hFFFF_FFFC; #1;
        chk("wrap", pc_next, 32'h0);

        // halt and resume
        nxt(); pc = 32'h30; halt_req = 1; #1;
        chk_all("halt_req", 32'h34, 1, 0, 0, 0);
        nxt(); pc = 32'h34; halt_req = 0; #1;
        chk_all("halt1", 32'h34, 0, 0, 0, 1);
        nxt(); #1;
        chk_all("halt2", 32'h34, 0, 0, 0, 1);
        nxt(); resume = 1; #1;
        chk_all("resume", 32'h34, 0, 0, 0, 1);
        nxt(); resume = 0; #1;
        chk_all("res_run", 32'h38, 1, 0, 0, 0);
        nxt(); pc = 32'h38; #1;
        chk("res_seq", pc_next, 32'h3C);

        // trap wakes HALT
        nxt(); pc = 32'h50; halt_req = 1; #1;
        chk("halt_b", pc_next, 32'h54);
        nxt(); pc = 32'h54; halt_req = 0; trap = 1; #1;
        chk_all("halt_trap", 32'h100, 0, 1, 0, 1);
        nxt(); pc = 32'h100; trap = 0; #1;
        chk_all("post_trap", 32'h104, 1, 0, 0, 0);

        // branch then trap while waiting: trap target used
        nxt(); pc = 32'h60; imem_ready = 0; #1;
        chk("w2_run", pc_next, 32'h60);
        nxt(); branch_taken = 1; branch_target = 32'h80; #1;
        chk("w2_br", {31'd0, flush_if}, 32'd1);
        nxt(); branch_taken = 0; trap = 1; #1;
        chk_all("w2_trap", 32'h60, 1, 1, 0, 0);
        nxt(); trap = 0; imem_ready = 1; #1;
        chk("w2_ready", pc_next, 32'h100);

        // reset mid-wait discards the pending redirect
        nxt(); pc = 32'h70; imem_ready = 0; #1;
        chk("r_run", pc_next, 32'h70);
        nxt(); branch_taken = 1; branch_target = 32'h90; #1;
        chk("r_br", {31'd0, flush_if}, 32'd1);
        #2; rst = 1'b0; #1;
        chk_all("r_async", 32'h0, 0, 0, 0, 0);
        nxt(); branch_taken = 0; imem_ready = 1; pc = 32'h0; #1;
        chk_all("r_hold", 32'h0, 0, 0, 0, 0);
        nxt(); rst = 1'b1; #1;
        chk_all("r_boot", 32'h0, 0, 0, 0, 0);
        nxt(); #1;
        chk_all("r_run0", 32'h4, 1, 0, 0, 0);
        nxt(); pc = 32'h4; #1;
        chk("r_seq", pc_next, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Computes `pc_next` for the PC register every cycle, plus the fetch request to instruction memory.
- Arbitrates four sources of the next PC: sequential increment, branch/jump redirect, trap vector, and hold (stall, memory wait or halt).
- Sits between the execute/hazard logic and the PC register; the PC register has no enable, so holding means driving `pc_next = pc`.

Parameters:
- RESET_VECTOR, 32'h00000000, first fetch address after reset.
- TRAP_VECTOR, 32'h00000100, target on trap or misaligned redirect.
- XLEN, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- pc  in  XLEN  current PC register value.
- stall  in  1  hazard unit: hold PC.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  XLEN  redirect address.
- trap  in  1  exception request, highest priority.
- halt_req  in  1  enter HALT after the current fetch completes.
- resume  in  1  leave HALT.
- imem_ready  in  1  instruction memory accepted/returned this cycle.
- pc_next  out  XLEN  to PC register.
- imem_req  out  1  fetch request for address `pc`.
- flush_if  out  1  one-cycle kill of the IF/ID stage.
- misalign  out  1  one-cycle pulse: redirect target had [1:0] != 0.
- halted  out  1  high in HALT.

Behaviour:
- Reset (rst=0), asynchronous:
  - state = BOOT, `pending_valid` = 0, `pending_addr` = 0.
  - Outputs: `pc_next` = RESET_VECTOR, `imem_req` = 0, `flush_if` = 0, `misalign` = 0, `halted` = 0.
- BOOT:
  - Lasts one cycle after reset release.
  - `pc_next` = RESET_VECTOR, `imem_req` = 0, then go to RUN.
- RUN:
  - `imem_req` = 1.
  - `pc_next` priority, highest first:
    - trap: TRAP_VECTOR, `flush_if` = 1.
    - branch_taken with target[1:0] == 0: `branch_target`, `flush_if` = 1.
    - branch_taken with target[1:0] != 0: TRAP_VECTOR, `flush_if` = 1, `misalign` = 1.
    - stall or !imem_ready: `pc`.
    - otherwise: `pc` + 4, wrapping modulo 2^XLEN (32'hFFFFFFFC -> 0).
  - !imem_ready with no trap/branch: go to WAIT.
  - halt_req with imem_ready: go to HALT, `pc_next` = `pc` + 4.
- WAIT:
  - `imem_req` = 1, `pc_next` = `pc`.
  - trap or branch_taken arriving here is latched into `pending_addr`/`pending_valid`; `flush_if` = 1 immediately. A later request overwrites an earlier one, and trap overwrites branch.
  - On imem_ready: `pc_next` = `pending_addr` if `pending_valid`, else `pc` + 4; clear `pending_valid`; go to RUN.
- HALT:
  - `imem_req` = 0, `halted` = 1, `pc_next` = `pc`.
  - resume: go to RUN next cycle.
  - trap: go to RUN with `pc_next` = TRAP_VECTOR.
- Simultaneous events:
  - stall and branch_taken: the redirect wins; the hazard unit must not assert both unless a flush is intended.
  - stall and trap: trap wins.
- Latency: `pc_next` is combinational from inputs and state; the PC updates on the following clock edge, i.e. one-cycle redirect latency.
- Reset mid-WAIT: pending redirect discarded; restart from BOOT.

Optional Feature:
- Macro `PC_SEQ_PERF_EN`.
- Defined:
  - Adds outputs `redirect_count` [31:0] and `stall_count` [31:0], both saturating and reset to 0.
  - `redirect_count` increments on every cycle `flush_if` = 1.
  - `stall_count` increments on every RUN/WAIT cycle where `pc_next` == `pc`.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - state enum {BOOT, RUN, WAIT, HALT} (2 bits).
  - INSTR_BYTES = 4.
  - Default RESET_VECTOR and TRAP_VECTOR constants.
- One sub-module, `pc_next_mux`: combinational priority select of `pc_next`, `flush_if` and `misalign`. FSM and pending register stay in the top.

Test Plan:
- Reset release, imem_ready=1 constant -> BOOT one cycle with `imem_req`=0; then `pc_next` 0x0, 0x4, 0x8, 0xC on successive cycles.
- pc=0x10, branch_taken=1, branch_target=0x40 -> `pc_next`=0x40 and `flush_if`=1 for exactly one cycle; next cycle `pc_next`=0x44.
- pc=0x20, imem_ready=0 for 3 cycles, branch_taken (target 0x80) in WAIT cycle 2, then imem_ready=1 -> `pc_next`=0x20 during wait; `flush_if` pulse on the request cycle; `pc_next`=0x80 when ready.
- branch_taken with target 0x42 -> `pc_next`=0x100, `misalign`=1 for one cycle; trap and branch together -> `pc_next`=0x100, `misalign`=0.
- halt_req at pc=0x30 -> `halted`=1, `imem_req`=0, `pc_next` held at 0x34; resume -> fetch continues 0x34, 0x38.
- rst asserted mid-WAIT with a pending redirect -> outputs at reset values asynchronously; after release, fetch restarts at 0x0 and the pending target is never used.
